// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA raster timing: sync, visible enable and pixel coordinates, all registered with zero skew.
// Counting starts one edge after the 2-flop lock synchroniser fills; no backpressure.
module vga_sync_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_column,
  output logic [9:0] pixel_row,
  output logic       frame_start,
  output logic       line_end
);

  localparam int         H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int         V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_LO = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_LO = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_sync1;
  logic       r_sync2;
  logic [9:0] r_col;
  logic [9:0] r_row;
  logic [9:0] w_col_nxt;
  logic [9:0] w_row_nxt;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_video_on;
  logic       r_frame_start;
  logic       r_line_end;
  logic       w_hsync_nxt;
  logic       w_vsync_nxt;
  logic       w_video_on_nxt;
  logic       w_frame_start_nxt;
  logic       w_line_end_nxt;

  // pll_locked is asynchronous to clk; r_sync2 is the synchronised run flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Outputs are computed from the next coordinates so they land in the same cycle as the counters.
  always_comb begin
    w_state_nxt       = r_sync2 ? S_RUN : S_IDLE;
    w_col_nxt         = '0;
    w_row_nxt         = '0;
    w_hsync_nxt       = ~SYNC_ACTIVE;
    w_vsync_nxt       = ~SYNC_ACTIVE;
    w_video_on_nxt    = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_line_end_nxt    = 1'b0;
    if (w_state_nxt == S_RUN && r_state == S_RUN) begin
      if (r_col == H_LAST) begin
        w_col_nxt = '0;
        w_row_nxt = (r_row == V_LAST) ? '0 : r_row + 10'd1;
      end else begin
        w_col_nxt = r_col + 10'd1;
        w_row_nxt = r_row;
      end
    end
    if (w_state_nxt == S_RUN) begin
      if (w_col_nxt >= H_SYNC_LO && w_col_nxt <= H_SYNC_HI) w_hsync_nxt = SYNC_ACTIVE;
      if (w_row_nxt >= V_SYNC_LO && w_row_nxt <= V_SYNC_HI) w_vsync_nxt = SYNC_ACTIVE;
      w_video_on_nxt    = (w_col_nxt < H_VIS) && (w_row_nxt < V_VIS);
      w_frame_start_nxt = (w_col_nxt == 10'd0) && (w_row_nxt == 10'd0);
      w_line_end_nxt    = (w_col_nxt == H_LAST);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col         <= '0;
      r_row         <= '0;
      r_hsync       <= ~SYNC_ACTIVE;
      r_vsync       <= ~SYNC_ACTIVE;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_end    <= 1'b0;
    end else begin
      r_col         <= w_col_nxt;
      r_row         <= w_row_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_video_on_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_line_end    <= w_line_end_nxt;
    end
  end

  assign hsync        = r_hsync;
  assign vsync        = r_vsync;
  assign video_on     = r_video_on;
  assign pixel_column = r_col;
  assign pixel_row    = r_row;
  assign frame_start  = r_frame_start;
  assign line_end     = r_line_end;

endmodule
